// File: rtl/pci_pkg.sv
// Shared PCI command codes, transaction result codes and initiator states.
package pci_pkg;

  localparam logic [3:0] MEM_READ        = 4'b0110;
  localparam logic [3:0] MEM_WRITE       = 4'b0111;
  localparam logic [3:0] MEM_READ_MUL    = 4'b1100;
  localparam logic [3:0] MEM_READ_LINE   = 4'b1110;
  localparam logic [3:0] MEM_WRITE_INVAL = 4'b1111;

  typedef enum logic [1:0] {
    OK           = 2'd0,
    DISC_DATA    = 2'd1,
    RETRY        = 2'd2,
    MASTER_ABORT = 2'd3
  } pci_status_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    LAST = 3'd3,
    TURN = 3'd4
  } pci_state_e;

  function automatic logic even_par(input logic [35:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pci_parity_gen.sv
// PAR generator: parity of this clock's AD/CBE is presented on the next clock,
// driven only when the initiator drove AD in the clock it covers.
module pci_parity_gen
  import pci_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ad,
  input  logic [3:0]  cbe,
  input  logic        oe,
  output logic        par,
  output logic        par_oe
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par    <= 1'b0;
      par_oe <= 1'b0;
    end else begin
      par    <= even_par({ad, cbe});
      par_oe <= oe;
    end
  end

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master running single/burst memory transactions.
// Handshake: wdata_ack is high in the clock the current wdata is taken (next word due after that edge); rdata_valid pulses the clock after a word is captured.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int LEN_W          = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             FRAME,
  output logic             IRDY,
  output logic [3:0]       CBE,
  inout  wire  [31:0]      AD,
  inout  wire              PAR,
  input  logic             TRDY,
  input  logic             DEVSEL,
  input  logic             STOP,
  input  logic             start,
  input  logic [3:0]       cmd,
  input  logic [31:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic             wdata_ack,
  output logic [31:0]      rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [LEN_W-1:0] xfer_count,
  output pci_state_e       dbg_state
);

  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);

  pci_state_e       state;
  pci_status_e      status_q;
  logic [3:0]       cmd_q;
  logic [3:0]       be_q;
  logic [31:0]      ad_q;
  logic             ad_oe;
  logic [LEN_W-1:0] remain;
  logic [TW-1:0]    dev_cnt;
  logic             dev_seen;
  logic             is_wr;
  logic             abort;
  logic             xfer;
  logic [31:0]      ad_drv;
  logic             par_val;
  logic             par_oe;

  assign is_wr  = cmd_q[0];
  // Abort wins over anything the target shows once the DEVSEL window has expired.
  assign abort  = (state == DATA) && !dev_seen && DEVSEL &&
                  (dev_cnt == TW'(DEVSEL_TIMEOUT - 1));
  assign xfer   = (state == DATA) && !TRDY && !abort;
  assign ad_drv = (is_wr && (state == DATA || state == LAST)) ? wdata : ad_q;

  assign AD        = ad_oe ? ad_drv : 32'bz;
  assign PAR       = par_oe ? par_val : 1'bz;
  assign wdata_ack = xfer && is_wr;
  assign status    = status_q;
  assign dbg_state = state;

  pci_parity_gen u_parity (
    .clk    (CLK),
    .rst_n  (RST),
    .ad     (ad_drv),
    .cbe    (CBE),
    .oe     (ad_oe),
    .par    (par_val),
    .par_oe (par_oe)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      status_q    <= OK;
      cmd_q       <= 4'h0;
      be_q        <= 4'hF;
      ad_q        <= 32'h0;
      ad_oe       <= 1'b0;
      remain      <= '0;
      dev_cnt     <= '0;
      dev_seen    <= 1'b0;
      FRAME       <= 1'b1;
      IRDY        <= 1'b1;
      CBE         <= 4'hF;
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      xfer_count  <= '0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && len != '0) begin
            state      <= ADDR;
            busy       <= 1'b1;
            cmd_q      <= cmd;
            be_q       <= be;
            remain     <= len;
            xfer_count <= '0;
            dev_cnt    <= '0;
            dev_seen   <= 1'b0;
            FRAME      <= 1'b0;
            IRDY       <= 1'b1;
            CBE        <= cmd;
            ad_q       <= addr;
            ad_oe      <= 1'b1;
          end
        end
        ADDR: begin
          state <= DATA;
          IRDY  <= 1'b0;
          CBE   <= be_q;
          FRAME <= (remain == LEN_W'(1));
          ad_oe <= is_wr;
        end
        DATA: begin
          if (!DEVSEL) dev_seen <= 1'b1;
          if (abort) begin
            status_q <= MASTER_ABORT;
            state    <= LAST;
            FRAME    <= 1'b1;
          end else begin
            if (!dev_seen && DEVSEL) dev_cnt <= dev_cnt + TW'(1);
            if (xfer) begin
              xfer_count <= xfer_count + LEN_W'(1);
              remain     <= remain - LEN_W'(1);
              if (!is_wr) begin
                rdata       <= AD;
                rdata_valid <= 1'b1;
              end
              if (remain == LEN_W'(1)) begin
                status_q <= OK;
                state    <= TURN;
                FRAME    <= 1'b1;
                IRDY     <= 1'b1;
                CBE      <= 4'hF;
                ad_oe    <= 1'b0;
                done     <= 1'b1;
              end else if (!STOP) begin
                status_q <= DISC_DATA;
                state    <= LAST;
                FRAME    <= 1'b1;
              end else begin
                FRAME <= (remain == LEN_W'(2));
              end
            end else if (!STOP) begin
              status_q <= (xfer_count != '0) ? DISC_DATA : RETRY;
              state    <= LAST;
              FRAME    <= 1'b1;
            end
          end
        end
        LAST: begin
          state <= TURN;
          FRAME <= 1'b1;
          IRDY  <= 1'b1;
          CBE   <= 4'hF;
          ad_oe <= 1'b0;
          done  <= 1'b1;
        end
        TURN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
